// File: rtl/miter_pkg.sv
// Shared types and default parameters for the keyed miter scoreboard.
package miter_pkg;

  localparam int DEF_N_OUT = 2;
  localparam int DEF_KEY_W = 6;
  localparam int DEF_VEC_W = 16;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/key_shift_reg.sv
// Serial MSB-first key loader: a shadow register collects bits, and the full
// key is committed to the locked circuit only when the last bit arrives.
module key_shift_reg
  import miter_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W
) (
  input  logic             C,
  input  logic             R,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_key_bit,
  output logic [KEY_W-1:0] lockingkeyinput,
  output logic             key_ready,
  output logic             load_done
);

  localparam int CW = $clog2(KEY_W + 1);

  logic [CW-1:0]    r_cnt;
  logic [KEY_W-1:0] r_shadow;
  logic [KEY_W-1:0] r_key;
  logic             r_ready;

  logic [KEY_W-1:0] w_shifted;
  logic             w_last;

  assign w_shifted = {r_shadow[KEY_W-2:0], i_key_bit};
  assign w_last    = i_shift && (r_cnt == CW'(KEY_W - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge C) begin
    if (R) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_key    <= '0;
      r_ready  <= 1'b0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_ready  <= 1'b0;
    end else if (i_shift) begin
      r_shadow <= w_shifted;
      if (w_last) begin
        r_cnt   <= '0;
        r_key   <= w_shifted;
        r_ready <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // The previous key stays on the locked circuit until a complete new key lands.
  assign lockingkeyinput = r_key;
  assign key_ready       = r_ready;
  assign load_done       = w_last;

endmodule

// File: rtl/keyed_miter_scoreboard.sv
// Miter scoreboard: drives a committed key into the locked circuit and
// accumulates bitwise output mismatches against the original circuit per run.
module keyed_miter_scoreboard
  import miter_pkg::*;
#(
  parameter int N_OUT = DEF_N_OUT,
  parameter int KEY_W = DEF_KEY_W,
  parameter int VEC_W = DEF_VEC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             C,
  input  logic             R,
  input  logic             key_load,
  input  logic             key_bit,
  input  logic             key_bit_valid,
  input  logic             run_start,
  input  logic [VEC_W-1:0] run_len,
  input  logic             cmp_valid,
  input  logic [N_OUT-1:0] org_y,
  input  logic [N_OUT-1:0] enc_y,
  output logic [KEY_W-1:0] lockingkeyinput,
  output logic             key_ready,
  output logic             busy,
  output logic [N_OUT-1:0] Q,
  output logic             Z,
  output logic [N_OUT-1:0] fail_mask,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_seen,
  output logic             done
);

  state_t r_state;
  state_t w_next;

  logic [VEC_W-1:0] r_idx;
  logic [VEC_W-1:0] r_len;
  logic [N_OUT-1:0] r_q;
  logic             r_z;
  logic [N_OUT-1:0] r_fail_mask;
  logic [CNT_W-1:0] r_cnt;
  logic [VEC_W-1:0] r_ffv;
  logic             r_ffs;

  logic             w_key_clear;
  logic             w_shift;
  logic             w_key_ready;
  logic             w_load_done;
  logic             w_idle_like;
  logic             w_run_enter;
  logic             w_cmp;
  logic             w_last_vec;
  logic [N_OUT-1:0] w_eq;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  // A key load is honoured from IDLE, DONE and (as a restart) LOAD, never in RUN.
  assign w_key_clear = key_load && (r_state != ST_RUN);
  assign w_shift     = (r_state == ST_LOAD) && key_bit_valid && !key_load;
  assign w_run_enter = w_idle_like && run_start && !key_load && w_key_ready;
  assign w_cmp       = (r_state == ST_RUN) && cmp_valid;
  assign w_last_vec  = w_cmp && (r_idx == (r_len - VEC_W'(1)));
  assign w_eq        = ~(org_y ^ enc_y);

  key_shift_reg #(
    .KEY_W(KEY_W)
  ) u_key (
    .C              (C),
    .R              (R),
    .i_clear        (w_key_clear),
    .i_shift        (w_shift),
    .i_key_bit      (key_bit),
    .lockingkeyinput(lockingkeyinput),
    .key_ready      (w_key_ready),
    .load_done      (w_load_done)
  );

  always_ff @(posedge C) begin
    if (R) r_state <= ST_IDLE;
    else   r_state <= w_next;
  end

  // NOTE: the default assignment before the case keeps this block purely
  // combinational; without it an unhandled path would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (key_load)         w_next = ST_LOAD;
        else if (w_run_enter) w_next = (run_len == '0) ? ST_DONE : ST_RUN;
      end
      ST_LOAD: if (w_load_done) w_next = ST_IDLE;
      ST_RUN:  if (w_last_vec)  w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_idx       <= '0;
      r_len       <= '0;
      r_q         <= '0;
      r_z         <= 1'b0;
      r_fail_mask <= '0;
      r_cnt       <= '0;
      r_ffv       <= '0;
      r_ffs       <= 1'b0;
    end else if (w_run_enter) begin
      r_idx       <= '0;
      r_len       <= run_len;
      r_fail_mask <= '0;
      r_cnt       <= '0;
      r_ffv       <= '0;
      r_ffs       <= 1'b0;
    end else if (w_cmp) begin
      r_q         <= w_eq;
      r_z         <= &w_eq;
      r_fail_mask <= r_fail_mask | ~w_eq;
      if (!(&w_eq)) begin
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        if (!r_ffs) begin
          r_ffv <= r_idx;
          r_ffs <= 1'b1;
        end
      end
      r_idx <= r_idx + VEC_W'(1);
    end
  end

  assign key_ready       = w_key_ready;
  assign busy            = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign done            = (r_state == ST_DONE);
  assign Q               = r_q;
  assign Z               = r_z;
  assign fail_mask       = r_fail_mask;
  assign mismatch_cnt    = r_cnt;
  assign first_fail_vec  = r_ffv;
  assign first_fail_seen = r_ffs;

endmodule

// File: tb/tb_keyed_miter_scoreboard.sv
// Directed bench for keyed_miter_scoreboard: a default-width instance plus a
// 2-bit-counter instance sharing the same stimulus.
module tb_keyed_miter_scoreboard;

  localparam int N_OUT = 2;
  localparam int KEY_W = 6;
  localparam int VEC_W = 16;
  localparam int CNT_W = 16;
  localparam int SAT_W = 2;

  logic             C = 1'b0;
  logic             R = 1'b1;
  logic             key_load = 1'b0;
  logic             key_bit = 1'b0;
  logic             key_bit_valid = 1'b0;
  logic             run_start = 1'b0;
  logic [VEC_W-1:0] run_len = '0;
  logic             cmp_valid = 1'b0;
  logic [N_OUT-1:0] org_y = '0;
  logic [N_OUT-1:0] enc_y = '0;

  logic [KEY_W-1:0] lki;
  logic             key_ready, busy, Z, ffs, done;
  logic [N_OUT-1:0] Q, fail_mask;
  logic [CNT_W-1:0] cnt;
  logic [VEC_W-1:0] ffv;

  logic [KEY_W-1:0] s_lki;
  logic             s_key_ready, s_busy, s_Z, s_ffs, s_done;
  logic [N_OUT-1:0] s_Q, s_fail_mask;
  logic [SAT_W-1:0] s_cnt;
  logic [VEC_W-1:0] s_ffv;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 C = ~C;

  keyed_miter_scoreboard #(
    .N_OUT(N_OUT), .KEY_W(KEY_W), .VEC_W(VEC_W), .CNT_W(CNT_W)
  ) dut (
    .C(C), .R(R), .key_load(key_load), .key_bit(key_bit), .key_bit_valid(key_bit_valid),
    .run_start(run_start), .run_len(run_len), .cmp_valid(cmp_valid),
    .org_y(org_y), .enc_y(enc_y), .lockingkeyinput(lki), .key_ready(key_ready),
    .busy(busy), .Q(Q), .Z(Z), .fail_mask(fail_mask), .mismatch_cnt(cnt),
    .first_fail_vec(ffv), .first_fail_seen(ffs), .done(done)
  );

  keyed_miter_scoreboard #(
    .N_OUT(N_OUT), .KEY_W(KEY_W), .VEC_W(VEC_W), .CNT_W(SAT_W)
  ) dut_sat (
    .C(C), .R(R), .key_load(key_load), .key_bit(key_bit), .key_bit_valid(key_bit_valid),
    .run_start(run_start), .run_len(run_len), .cmp_valid(cmp_valid),
    .org_y(org_y), .enc_y(enc_y), .lockingkeyinput(s_lki), .key_ready(s_key_ready),
    .busy(s_busy), .Q(s_Q), .Z(s_Z), .fail_mask(s_fail_mask), .mismatch_cnt(s_cnt),
    .first_fail_vec(s_ffv), .first_fail_seen(s_ffs), .done(s_done)
  );

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic start_run(input int len);
    run_len   = VEC_W'(len);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
  endtask

  task automatic send(input logic [N_OUT-1:0] o, input logic [N_OUT-1:0] e);
    org_y     = o;
    enc_y     = e;
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    key_bit       = b;
    key_bit_valid = 1'b1;
    tick();
    key_bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    R = 1'b1;
    tick();
    tick();
    R = 1'b0;
    n_cmp++; if (lki !== 6'h00) begin n_bad++; $display("FAIL reset_key: got %h want %h", lki, 6'h00); end
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL reset_key_ready: got %b want 0", key_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if ({Q, Z} !== 3'b000) begin n_bad++; $display("FAIL reset_qz: got %b want 000", {Q, Z}); end
    n_cmp++; if (fail_mask !== 2'b00) begin n_bad++; $display("FAIL reset_mask: got %b want 00", fail_mask); end
    n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    n_cmp++; if ({ffv, ffs} !== 17'd0) begin n_bad++; $display("FAIL reset_first: got vec %0d seen %b want 0/0", ffv, ffs); end
    n_cmp++; if (s_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_sat_cnt: got %0d want 0", s_cnt); end
  endtask

  task automatic test_key_load();
    logic [KEY_W-1:0] k;
    k = 6'b101101;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL load_busy: got %b want 1", busy); end
    for (int i = KEY_W - 1; i >= 0; i--) begin
      shift_bit(k[i]);
      if (i != 0) begin
        n_cmp++; if (lki !== 6'h00) begin n_bad++; $display("FAIL load_hold_bit%0d: got %h want 00", i, lki); end
        n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_early_bit%0d: got %b want 0", i, key_ready); end
        tick();
      end
    end
    n_cmp++; if (lki !== 6'h2D) begin n_bad++; $display("FAIL load_commit: got %h want 2d", lki); end
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %b want 1", key_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL load_back_idle: busy got %b want 0", busy); end
    n_cmp++; if (s_lki !== 6'h2D) begin n_bad++; $display("FAIL load_commit_sat: got %h want 2d", s_lki); end
  endtask

  task automatic test_reload_restart();
    logic [KEY_W-1:0] k;
    k = 6'b010010;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL reload_ready_clear: got %b want 0", key_ready); end
    n_cmp++; if (lki !== 6'h2D) begin n_bad++; $display("FAIL reload_hold: got %h want 2d", lki); end
    shift_bit(1'b1);
    shift_bit(1'b1);
    shift_bit(1'b1);
    key_load = 1'b1;
    key_bit = 1'b1;
    key_bit_valid = 1'b1;
    tick();
    key_load = 1'b0;
    key_bit_valid = 1'b0;
    run_len = 16'd3;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL reload_run_ignored: busy/done got %b want 10", {busy, done}); end
    for (int i = KEY_W - 1; i >= 0; i--) begin
      shift_bit(k[i]);
      if (i != 0) begin
        n_cmp++; if (lki !== 6'h2D) begin n_bad++; $display("FAIL reload_hold_bit%0d: got %h want 2d", i, lki); end
      end
    end
    n_cmp++; if (lki !== 6'h12) begin n_bad++; $display("FAIL reload_commit: got %h want 12", lki); end
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL reload_ready: got %b want 1", key_ready); end
  endtask

  task automatic test_all_equal();
    logic [N_OUT-1:0] v [4];
    v = '{2'b00, 2'b11, 2'b01, 2'b10};
    start_run(4);
    n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL eq_enter_run: busy/done got %b want 10", {busy, done}); end
    for (int i = 0; i < 4; i++) begin
      send(v[i], v[i]);
      n_cmp++; if ({Q, Z} !== 3'b111) begin n_bad++; $display("FAIL eq_qz_v%0d: got %b want 111", i, {Q, Z}); end
      n_cmp++; if (done !== (i == 3)) begin n_bad++; $display("FAIL eq_done_v%0d: got %b want %b", i, done, (i == 3)); end
    end
    n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL eq_cnt: got %0d want 0", cnt); end
    n_cmp++; if (fail_mask !== 2'b00) begin n_bad++; $display("FAIL eq_mask: got %b want 00", fail_mask); end
    n_cmp++; if (ffs !== 1'b0) begin n_bad++; $display("FAIL eq_first_seen: got %b want 0", ffs); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL eq_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_single_mismatch();
    start_run(3);
    send(2'b01, 2'b01);
    n_cmp++; if ({Q, Z, cnt} !== {3'b111, 16'd0}) begin n_bad++; $display("FAIL single_v0: got q/z %b cnt %0d want 111/0", {Q, Z}, cnt); end
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_gap_busy: got %b want 1", busy); end
    send(2'b10, 2'b00);
    n_cmp++; if ({Q, Z} !== 3'b010) begin n_bad++; $display("FAIL single_qz: got %b want 010", {Q, Z}); end
    n_cmp++; if (cnt !== 16'd1) begin n_bad++; $display("FAIL single_cnt_mid: got %0d want 1", cnt); end
    n_cmp++; if ({ffv, ffs} !== {16'd1, 1'b1}) begin n_bad++; $display("FAIL single_first_mid: got vec %0d seen %b want 1/1", ffv, ffs); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_early: got %b want 0", done); end
    send(2'b11, 2'b11);
    n_cmp++; if ({Q, Z} !== 3'b111) begin n_bad++; $display("FAIL single_qz_last: got %b want 111", {Q, Z}); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b want 1", done); end
    n_cmp++; if (cnt !== 16'd1) begin n_bad++; $display("FAIL single_cnt: got %0d want 1", cnt); end
    n_cmp++; if (ffv !== 16'd1) begin n_bad++; $display("FAIL single_first_vec: got %0d want 1", ffv); end
    n_cmp++; if (fail_mask !== 2'b10) begin n_bad++; $display("FAIL single_mask: got %b want 10", fail_mask); end
  endtask

  task automatic test_saturation();
    logic [N_OUT-1:0] o [5];
    logic [N_OUT-1:0] e [5];
    logic [SAT_W-1:0] es [5];
    o  = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10};
    e  = '{2'b11, 2'b00, 2'b10, 2'b00, 2'b01};
    es = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    start_run(5);
    n_cmp++; if ({cnt, fail_mask, ffs} !== 19'd0) begin n_bad++; $display("FAIL sat_clear: got cnt %0d mask %b seen %b want 0/00/0", cnt, fail_mask, ffs); end
    n_cmp++; if (s_cnt !== 2'd0) begin n_bad++; $display("FAIL sat_clear_small: got %0d want 0", s_cnt); end
    for (int i = 0; i < 5; i++) begin
      send(o[i], e[i]);
      n_cmp++; if (s_cnt !== es[i]) begin n_bad++; $display("FAIL sat_cnt_v%0d: got %0d want %0d", i, s_cnt, es[i]); end
      n_cmp++; if (cnt !== 16'(i + 1)) begin n_bad++; $display("FAIL sat_wide_cnt_v%0d: got %0d want %0d", i, cnt, i + 1); end
    end
    n_cmp++; if ({ffv, s_ffv} !== 32'd0) begin n_bad++; $display("FAIL sat_first_vec: got %0d/%0d want 0/0", ffv, s_ffv); end
    n_cmp++; if (fail_mask !== 2'b11) begin n_bad++; $display("FAIL sat_mask: got %b want 11", fail_mask); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL sat_done: got %b want 1", done); end
    send(2'b01, 2'b00);
    n_cmp++; if ({cnt, s_cnt} !== {16'd5, 2'd3}) begin n_bad++; $display("FAIL done_cmp_ignored_cnt: got %0d/%0d want 5/3", cnt, s_cnt); end
    n_cmp++; if ({Q, Z} !== 3'b000) begin n_bad++; $display("FAIL done_cmp_ignored_qz: got %b want 000", {Q, Z}); end
  endtask

  task automatic test_reset_gating();
    start_run(6);
    send(2'b00, 2'b11);
    send(2'b00, 2'b00);
    org_y = 2'b01;
    enc_y = 2'b10;
    cmp_valid = 1'b1;
    R = 1'b1;
    tick();
    R = 1'b0;
    cmp_valid = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL abort_state: busy/done got %b want 00", {busy, done}); end
    n_cmp++; if ({lki, key_ready} !== 7'd0) begin n_bad++; $display("FAIL abort_key: got %h ready %b want 00/0", lki, key_ready); end
    n_cmp++; if ({Q, Z, fail_mask} !== 5'd0) begin n_bad++; $display("FAIL abort_qzmask: got %b want 00000", {Q, Z, fail_mask}); end
    n_cmp++; if ({cnt, ffv, ffs} !== 33'd0) begin n_bad++; $display("FAIL abort_stats: got cnt %0d vec %0d seen %b want 0", cnt, ffv, ffs); end
    start_run(6);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL gate_no_key_busy: got %b want 0", busy); end
    send(2'b11, 2'b00);
    n_cmp++; if ({busy, done, cnt} !== 18'd0) begin n_bad++; $display("FAIL gate_no_key_run: got busy %b done %b cnt %0d want 0", busy, done, cnt); end
  endtask

  task automatic test_zero_len();
    logic [KEY_W-1:0] k;
    k = 6'h2D;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    for (int i = KEY_W - 1; i >= 0; i--) shift_bit(k[i]);
    n_cmp++; if ({lki, key_ready} !== {6'h2D, 1'b1}) begin n_bad++; $display("FAIL zl_key: got %h ready %b want 2d/1", lki, key_ready); end
    start_run(1);
    send(2'b11, 2'b00);
    n_cmp++; if ({done, cnt} !== {1'b1, 16'd1}) begin n_bad++; $display("FAIL zl_len1: got done %b cnt %0d want 1/1", done, cnt); end
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    n_cmp++; if ({busy, cnt, ffs, fail_mask} !== {1'b1, 16'd1, 1'b1, 2'b11}) begin n_bad++; $display("FAIL zl_stats_held: got busy %b cnt %0d seen %b mask %b want 1/1/1/11", busy, cnt, ffs, fail_mask); end
    for (int i = KEY_W - 1; i >= 0; i--) shift_bit(k[i]);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL zl_idle: busy/done got %b want 00", {busy, done}); end
    start_run(0);
    n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++; $display("FAIL zl_done: done/busy got %b want 10", {done, busy}); end
    n_cmp++; if ({cnt, fail_mask, ffv, ffs} !== 35'd0) begin n_bad++; $display("FAIL zl_stats: got cnt %0d mask %b vec %0d seen %b want 0", cnt, fail_mask, ffv, ffs); end
    n_cmp++; if (s_cnt !== 2'd0) begin n_bad++; $display("FAIL zl_sat_cnt: got %0d want 0", s_cnt); end
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_reload_restart();
    test_all_equal();
    test_single_mismatch();
    test_saturation();
    test_reset_gating();
    test_zero_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
